// File: rtl/vga_pkg.sv
// vga_pkg: shared types and helpers for the VGA raster timing generator.
//   vga_timing_t     : one complete raster description (active/porch/sync widths)
//   VGA_640x480_60   : standard 640x480 @ 60 Hz timing (25 MHz pixel clock)
//   h_total/v_total  : total pixels per line / lines per frame
//   in_window        : position-in-[lo, lo+width) compare used for sync pulses
package vga_pkg;

    typedef struct packed {
        int unsigned h_active;
        int unsigned h_fp;
        int unsigned h_sync;
        int unsigned h_bp;
        int unsigned v_active;
        int unsigned v_fp;
        int unsigned v_sync;
        int unsigned v_bp;
    } vga_timing_t;

    localparam vga_timing_t VGA_640x480_60 = '{
        h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33
    };

    function automatic int unsigned h_total(input vga_timing_t t);
        return t.h_active + t.h_fp + t.h_sync + t.h_bp;
    endfunction

    function automatic int unsigned v_total(input vga_timing_t t);
        return t.v_active + t.v_fp + t.v_sync + t.v_bp;
    endfunction

    // True when pos lies in the half-open window [lo, lo+width).
    function automatic logic in_window(input int unsigned pos,
                                       input int unsigned lo,
                                       input int unsigned width);
        return (pos >= lo) && (pos < lo + width);
    endfunction

endpackage

// File: rtl/pix_ce_div.sv
// pix_ce_div: system-clock to pixel-clock-enable divider.
//   clk_i    : system clock
//   rst_i    : synchronous active-high reset (counter -> 0, enable forced low)
//   pix_ce_o : one-clk-wide enable, high when the counter sits on CLK_DIV-1
// With CLK_DIV=1 the counter is a constant 0 and pix_ce_o is simply ~rst_i.
module pix_ce_div #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic pix_ce_o
);

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;

    always_comb begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // Decoded from the registered count so the enable is glitch-free; the
    // reset gate keeps it low during reset even when CLK_DIV=1.
    assign pix_ce_o = ~rst_i & (div_q == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator and DAC output stage.
//   clk, rst            : system clock, synchronous active-high reset
//   pix_ce              : pixel clock enable (one clk wide, every CLK_DIV clks)
//   x, y                : current raster position (combinational from counters)
//   active              : x/y inside the visible area
//   line_start          : pix_ce on x==0
//   frame_start         : pix_ce on x==0, y==0
//   r_i, g_i, b_i       : colour for the current x/y, sampled on pix_ce
//   test_pat_i          : select internal colour bars
//   r, g, b             : registered, blanked colour to the DAC
//   h_sync, v_sync      : registered syncs, asserted level SYNC_POL
//   blank_n             : registered, high during visible pixels
//   sync_b              : composite sync, tied low
// Build option: define VGA_TEST_PATTERN_EN to enable the 8-bar test pattern;
// without it test_pat_i is accepted but ignored.
// All DAC outputs are registered on the same pix_ce, so colour and syncs carry
// exactly one pixel tick of latency relative to x/y and stay aligned.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned CLK_DIV  = 2,
    parameter bit          SYNC_POL = 1'b0,
    parameter int unsigned COLOR_W  = 8
) (
    input  logic                                              clk,
    input  logic                                              rst,
    output logic                                              pix_ce,
    output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]      x,
    output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]      y,
    output logic                                              active,
    output logic                                              line_start,
    output logic                                              frame_start,
    input  logic [COLOR_W-1:0]                                r_i,
    input  logic [COLOR_W-1:0]                                g_i,
    input  logic [COLOR_W-1:0]                                b_i,
    input  logic                                              test_pat_i,
    output logic [COLOR_W-1:0]                                r,
    output logic [COLOR_W-1:0]                                g,
    output logic [COLOR_W-1:0]                                b,
    output logic                                              h_sync,
    output logic                                              v_sync,
    output logic                                              blank_n,
    output logic                                              sync_b
);

    localparam vga_timing_t TIMING = '{
        h_active: H_ACTIVE, h_fp: H_FP, h_sync: H_SYNC, h_bp: H_BP,
        v_active: V_ACTIVE, v_fp: V_FP, v_sync: V_SYNC, v_bp: V_BP
    };
    localparam int unsigned H_TOTAL = h_total(TIMING);
    localparam int unsigned V_TOTAL = v_total(TIMING);
    localparam int unsigned XW      = $clog2(H_TOTAL);
    localparam int unsigned YW      = $clog2(V_TOTAL);
    localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);

    generate
        if (CLK_DIV == 0 || H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 ||
            H_BP == 0 || V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 ||
            V_BP == 0 || COLOR_W == 0) begin : g_bad_params
            $error("vga_timing_gen: CLK_DIV and all width parameters must be >= 1");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Pixel clock enable
    // ------------------------------------------------------------------
    pix_ce_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_ce_div (
        .clk_i    (clk),
        .rst_i    (rst),
        .pix_ce_o (pix_ce)
    );

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (pix_ce) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign active      = (32'(x_q) < H_ACTIVE) && (32'(y_q) < V_ACTIVE);
    assign line_start  = pix_ce && (x_q == '0);
    assign frame_start = line_start && (y_q == '0);

    // ------------------------------------------------------------------
    // Colour source selection
    // ------------------------------------------------------------------
    logic [COLOR_W-1:0] src_r, src_g, src_b;

`ifdef VGA_TEST_PATTERN_EN
    // Bar index only matters while active (x < H_ACTIVE), where it is 0..7.
    logic [31:0] bar_idx;
    logic        unused_bar_hi;

    assign bar_idx       = (32'(x_q) * 32'd8) / H_ACTIVE;
    assign unused_bar_hi = ^bar_idx[31:3];
    assign src_r = test_pat_i ? {COLOR_W{bar_idx[2]}} : r_i;
    assign src_g = test_pat_i ? {COLOR_W{bar_idx[1]}} : g_i;
    assign src_b = test_pat_i ? {COLOR_W{bar_idx[0]}} : b_i;
`else
    logic unused_test_pat;

    assign unused_test_pat = test_pat_i;
    assign src_r = r_i;
    assign src_g = g_i;
    assign src_b = b_i;
`endif

    // ------------------------------------------------------------------
    // DAC output stage
    // ------------------------------------------------------------------
    logic [COLOR_W-1:0] r_q, g_q, b_q;
    logic               h_sync_q, v_sync_q, blank_n_q;
    logic               h_sync_d, v_sync_d;

    always_comb begin
        h_sync_d = in_window(32'(x_q), H_ACTIVE + H_FP, H_SYNC) ? SYNC_POL : ~SYNC_POL;
        v_sync_d = in_window(32'(y_q), V_ACTIVE + V_FP, V_SYNC) ? SYNC_POL : ~SYNC_POL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
            blank_n_q <= 1'b0;
            h_sync_q  <= ~SYNC_POL;
            v_sync_q  <= ~SYNC_POL;
        end else if (pix_ce) begin
            r_q       <= active ? src_r : '0;
            g_q       <= active ? src_g : '0;
            b_q       <= active ? src_b : '0;
            blank_n_q <= active;
            h_sync_q  <= h_sync_d;
            v_sync_q  <= v_sync_d;
        end
    end

    assign r       = r_q;
    assign g       = g_q;
    assign b       = b_q;
    assign blank_n = blank_n_q;
    assign h_sync  = h_sync_q;
    assign v_sync  = v_sync_q;
    assign sync_b  = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances with different timing, divider and
// sync polarity share clock, reset and colour stimulus. Expected behaviour is
// derived arithmetically from the number of clocks since reset:
//   ticks = clocks / CLK_DIV, x = ticks mod H_TOTAL, y = (ticks / H_TOTAL) mod V_TOTAL.
module tb_vga_timing_gen;

    localparam int ND = 3;

`ifdef VGA_TEST_PATTERN_EN
    localparam bit TP_BUILD = 1'b1;
`else
    localparam bit TP_BUILD = 1'b0;
`endif

    // Per-instance configuration (index 0: tiny/div1, 1: tiny/div3/pos, 2: wide/div2)
    int HA  [ND] = '{8, 8, 16};
    int HF  [ND] = '{1, 1, 1};
    int HS  [ND] = '{2, 2, 2};
    int HB  [ND] = '{1, 1, 1};
    int VA  [ND] = '{4, 4, 4};
    int VF  [ND] = '{1, 1, 1};
    int VS  [ND] = '{1, 1, 1};
    int VB  [ND] = '{1, 1, 1};
    int DIV [ND] = '{1, 3, 2};
    bit POL [ND] = '{1'b0, 1'b1, 1'b0};

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] r_i, g_i, b_i;
    logic       test_pat_i;

    // ---------------- DUT signals ----------------
    logic       ce_a, act_a, ls_a, fs_a, hs_a, vs_a, bn_a, sb_a;
    logic [3:0] x_a;
    logic [2:0] y_a;
    logic [7:0] r_a, g_a, b_a;

    logic       ce_b, act_b, ls_b, fs_b, hs_b, vs_b, bn_b, sb_b;
    logic [3:0] x_b;
    logic [2:0] y_b;
    logic [7:0] r_b, g_b, b_b;

    logic       ce_c, act_c, ls_c, fs_c, hs_c, vs_c, bn_c, sb_c;
    logic [4:0] x_c;
    logic [2:0] y_c;
    logic [7:0] r_c, g_c, b_c;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(1), .SYNC_POL(1'b0), .COLOR_W(8)
    ) dut_a (
        .clk(clk), .rst(rst), .pix_ce(ce_a), .x(x_a), .y(y_a), .active(act_a),
        .line_start(ls_a), .frame_start(fs_a), .r_i(r_i), .g_i(g_i), .b_i(b_i),
        .test_pat_i(test_pat_i), .r(r_a), .g(g_a), .b(b_a), .h_sync(hs_a),
        .v_sync(vs_a), .blank_n(bn_a), .sync_b(sb_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(3), .SYNC_POL(1'b1), .COLOR_W(8)
    ) dut_b (
        .clk(clk), .rst(rst), .pix_ce(ce_b), .x(x_b), .y(y_b), .active(act_b),
        .line_start(ls_b), .frame_start(fs_b), .r_i(r_i), .g_i(g_i), .b_i(b_i),
        .test_pat_i(test_pat_i), .r(r_b), .g(g_b), .b(b_b), .h_sync(hs_b),
        .v_sync(vs_b), .blank_n(bn_b), .sync_b(sb_b)
    );

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(2), .SYNC_POL(1'b0), .COLOR_W(8)
    ) dut_c (
        .clk(clk), .rst(rst), .pix_ce(ce_c), .x(x_c), .y(y_c), .active(act_c),
        .line_start(ls_c), .frame_start(fs_c), .r_i(r_i), .g_i(g_i), .b_i(b_i),
        .test_pat_i(test_pat_i), .r(r_c), .g(g_c), .b(b_c), .h_sync(hs_c),
        .v_sync(vs_c), .blank_n(bn_c), .sync_b(sb_c)
    );

    // ---------------- scoreboard ----------------
    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state: clocks since reset and the expected DAC registers.
    int k   [ND];
    int er  [ND];
    int eg  [ND];
    int eb  [ND];
    bit ehs [ND];
    bit evs [ND];
    bit ebn [ND];

    function automatic void model_now(input int d, input int kk, input bit rst_v,
                                      output int mx, output int my, output bit mce,
                                      output bit mact, output bit mls, output bit mfs);
        int ht, vt, ticks;
        ht    = HA[d] + HF[d] + HS[d] + HB[d];
        vt    = VA[d] + VF[d] + VS[d] + VB[d];
        ticks = kk / DIV[d];
        mx    = ticks % ht;
        my    = (ticks / ht) % vt;
        mce   = !rst_v && ((kk % DIV[d]) == DIV[d] - 1);
        mact  = (mx < HA[d]) && (my < VA[d]);
        mls   = mce && (mx == 0);
        mfs   = mls && (my == 0);
    endfunction

    function automatic int bar_level(input int d, input int mx, input int bitpos,
                                     input int fallback);
        int bar;
        if (TP_BUILD && test_pat_i) begin
            bar = (mx * 8) / HA[d];
            return ((bar >> bitpos) & 1) ? 255 : 0;
        end
        return fallback;
    endfunction

    task automatic model_reset(input int d);
        k[d]   = 0;
        er[d]  = 0;
        eg[d]  = 0;
        eb[d]  = 0;
        ebn[d] = 1'b0;
        ehs[d] = !POL[d];
        evs[d] = !POL[d];
    endtask

    task automatic model_edge(input int d);
        int mx, my;
        bit mce, mact, mls, mfs;
        model_now(d, k[d], rst, mx, my, mce, mact, mls, mfs);
        if (rst) begin
            model_reset(d);
        end else begin
            if (mce) begin
                er[d]  = mact ? bar_level(d, mx, 2, int'(r_i)) : 0;
                eg[d]  = mact ? bar_level(d, mx, 1, int'(g_i)) : 0;
                eb[d]  = mact ? bar_level(d, mx, 0, int'(b_i)) : 0;
                ebn[d] = mact;
                ehs[d] = (mx >= HA[d] + HF[d] && mx < HA[d] + HF[d] + HS[d]) ? POL[d] : !POL[d];
                evs[d] = (my >= VA[d] + VF[d] && my < VA[d] + VF[d] + VS[d]) ? POL[d] : !POL[d];
            end
            k[d]++;
        end
    endtask

    task automatic check_dut(input int d, input int ox, input int oy, input bit oce,
                             input bit oact, input bit ols, input bit ofs,
                             input int orr, input int ogg, input int obb,
                             input bit ohs, input bit ovs, input bit obn, input bit osb);
        int mx, my;
        bit mce, mact, mls, mfs;
        model_now(d, k[d], rst, mx, my, mce, mact, mls, mfs);
        check_eq($sformatf("x[%0d]", d),           ox,        mx);
        check_eq($sformatf("y[%0d]", d),           oy,        my);
        check_eq($sformatf("pix_ce[%0d]", d),      int'(oce),  int'(mce));
        check_eq($sformatf("active[%0d]", d),      int'(oact), int'(mact));
        check_eq($sformatf("line_start[%0d]", d),  int'(ols),  int'(mls));
        check_eq($sformatf("frame_start[%0d]", d), int'(ofs),  int'(mfs));
        check_eq($sformatf("r[%0d]", d),           orr,        er[d]);
        check_eq($sformatf("g[%0d]", d),           ogg,        eg[d]);
        check_eq($sformatf("b[%0d]", d),           obb,        eb[d]);
        check_eq($sformatf("h_sync[%0d]", d),      int'(ohs),  int'(ehs[d]));
        check_eq($sformatf("v_sync[%0d]", d),      int'(ovs),  int'(evs[d]));
        check_eq($sformatf("blank_n[%0d]", d),     int'(obn),  int'(ebn[d]));
        check_eq($sformatf("sync_b[%0d]", d),      int'(osb),  0);
    endtask

    task automatic check_all();
        check_dut(0, int'(x_a), int'(y_a), ce_a, act_a, ls_a, fs_a,
                  int'(r_a), int'(g_a), int'(b_a), hs_a, vs_a, bn_a, sb_a);
        check_dut(1, int'(x_b), int'(y_b), ce_b, act_b, ls_b, fs_b,
                  int'(r_b), int'(g_b), int'(b_b), hs_b, vs_b, bn_b, sb_b);
        check_dut(2, int'(x_c), int'(y_c), ce_c, act_c, ls_c, fs_c,
                  int'(r_c), int'(g_c), int'(b_c), hs_c, vs_c, bn_c, sb_c);
    endtask

    // Count of dut_a v_sync-low clocks inside one undisturbed frame.
    int vs_low_cnt;
    int frame_clks;
    bit counting;

    // ---------------- driver ----------------
    initial begin
        bit dir_done;
        bit rst_v;
        rst        = 1'b1;
        r_i        = '0;
        g_i        = '0;
        b_i        = '0;
        test_pat_i = 1'b0;
        dir_done   = 1'b0;
        counting   = 1'b0;
        vs_low_cnt = 0;
        frame_clks = 0;
        repeat (3) @(posedge clk);
        for (int d = 0; d < ND; d++) model_reset(d);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            rst_v = 1'b0;
            // One-clock reset mid-frame of dut_a at y=2, x=5 (tick 29 of its frame).
            if (!dir_done && cyc > 300 && (k[0] % 84) == 29) begin
                rst_v    = 1'b1;
                dir_done = 1'b1;
            end else if (cyc > 600 && $urandom_range(0, 299) == 0) begin
                rst_v = 1'b1;
            end
            rst        = rst_v;
            r_i        = 8'($urandom_range(0, 255));
            g_i        = 8'($urandom_range(0, 255));
            b_i        = 8'($urandom_range(0, 255));
            test_pat_i = 1'($urandom_range(0, 1));
            #1;
            check_all();

            // Frame-length sync check on dut_a during the reset-free opening frames.
            if (cyc < 300) begin
                if (fs_a && counting) begin
                    check_eq("vsync_low_clks", vs_low_cnt, 12);
                    check_eq("frame_period", frame_clks, 84);
                end
                if (fs_a) begin
                    counting   = 1'b1;
                    vs_low_cnt = 0;
                    frame_clks = 0;
                end
                if (counting) begin
                    frame_clks++;
                    if (!vs_a) vs_low_cnt++;
                end
            end

            @(posedge clk);
            for (int d = 0; d < ND; d++) model_edge(d);
        end

        check_eq("directed_reset_seen", int'(dir_done), 1);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
